// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: decodes the opcode and drives the
// datapath write strobes, mux selects and ALU controls, one state per cycle.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

    state_t r_state;

    // NOTE: state is sequential, so it uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:  if (MemReady) r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (Op == OP_LW || Op == OP_SW) r_state <= ST_MEMADR;
                    else if (Op == OP_RTYPE)        r_state <= ST_EXEC;
                    else if (Op == OP_BEQ)          r_state <= ST_BRANCH;
                    else if (Op == OP_J)            r_state <= ST_JUMP;
                    else if (Op == OP_ADDI)         r_state <= ST_ADDIEX;
                    else                            r_state <= ST_FETCH;
                end
                ST_MEMADR: r_state <= (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
                ST_MEMRD:  if (MemReady) r_state <= ST_MEMWB;
                ST_MEMWR:  if (MemReady) r_state <= ST_FETCH;
                ST_EXEC:   r_state <= ST_RWB;
                ST_ADDIEX: r_state <= ST_ADDIWB;
                ST_MEMWB, ST_RWB, ST_BRANCH, ST_JUMP, ST_ADDIWB:
                           r_state <= ST_FETCH;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    // Outputs are decoded from the state rather than registered: the Fetch
    // strobes follow MemReady and Illegal follows Op within the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Illegal     = 1'b0;
        State       = r_state;

        case (r_state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = MemReady;
                IRWrite = MemReady;
            end
            ST_DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = !(Op == OP_LW || Op == OP_SW || Op == OP_RTYPE ||
                            Op == OP_BEQ || Op == OP_J || Op == OP_ADDI);
            end
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ST_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ST_ADDIWB: RegWrite = 1'b1;
            default:   State = 4'd0;
        endcase

        // Reset held low silences every output, including the debug state.
        if (!Reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            Illegal     = 1'b0;
            State       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares the full output bundle against hand-written expectations.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, Illegal;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    // Bundle: State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
    // IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal
    localparam logic [21:0] E_ZERO   = {4'd0,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
    localparam logic [21:0] E_FWAIT  = {4'd0,  7'b0001000, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000};
    localparam logic [21:0] E_FGO    = {4'd0,  7'b1001001, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000};
    localparam logic [21:0] E_DEC    = {4'd1,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000};
    localparam logic [21:0] E_DECBAD = {4'd1,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b001};
    localparam logic [21:0] E_MEMADR = {4'd2,  7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000};
    localparam logic [21:0] E_MEMRD  = {4'd3,  7'b0011000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
    localparam logic [21:0] E_MEMWB  = {4'd4,  7'b0000010, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100};
    localparam logic [21:0] E_MEMWR  = {4'd5,  7'b0010100, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
    localparam logic [21:0] E_EXEC   = {4'd6,  7'b0000000, 2'b00, 2'b10, 1'b1, 2'b00, 3'b000};
    localparam logic [21:0] E_RWB    = {4'd7,  7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b110};
    localparam logic [21:0] E_BRANCH = {4'd8,  7'b0100000, 2'b01, 2'b01, 1'b1, 2'b00, 3'b000};
    localparam logic [21:0] E_JUMP   = {4'd9,  7'b1000000, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
    localparam logic [21:0] E_ADDIEX = {4'd10, 7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000};
    localparam logic [21:0] E_ADDIWB = {4'd11, 7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100};

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .Illegal(Illegal), .State(State)
    );

    always #5 Clk = ~Clk;

    function automatic logic [21:0] outs();
        return {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, Illegal};
    endfunction

    task automatic check(input string tag, input logic [21:0] actual, input logic [21:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Drive inputs just after a falling edge, check the settled outputs, then
    // advance to the next falling edge (one rising edge in between).
    task automatic cyc(input string tag, input logic mr, input logic [5:0] op,
                       input logic [21:0] expected);
        MemReady = mr;
        Op       = op;
        #1;
        check(tag, outs(), expected);
        @(negedge Clk);
    endtask

    initial begin
        Reset    = 1'b0;
        MemReady = 1'b1;
        Op       = LW;
        #2;
        check("reset_outputs_zero", outs(), E_ZERO);
        @(negedge Clk);
        Reset = 1'b1;

        // LW, no stalls: 0,1,2,3,4 then back to 0
        cyc("lw_fetch",  1'b1, LW, E_FGO);
        cyc("lw_decode", 1'b1, LW, E_DEC);
        cyc("lw_memadr", 1'b1, LW, E_MEMADR);
        cyc("lw_memrd",  1'b1, LW, E_MEMRD);
        cyc("lw_memwb",  1'b1, LW, E_MEMWB);

        // SW with two MemReady-low cycles in MEMWR
        cyc("sw_fetch",  1'b1, SW, E_FGO);
        cyc("sw_decode", 1'b1, SW, E_DEC);
        cyc("sw_memadr", 1'b1, SW, E_MEMADR);
        cyc("sw_memwr0", 1'b0, SW, E_MEMWR);
        cyc("sw_memwr1", 1'b0, SW, E_MEMWR);
        cyc("sw_memwr2", 1'b1, SW, E_MEMWR);

        // R-type, BEQ, J back to back; MemReady low outside FETCH is ignored
        cyc("rt_fetch",  1'b1, RT,  E_FGO);
        cyc("rt_decode", 1'b0, RT,  E_DEC);
        cyc("rt_exec",   1'b0, RT,  E_EXEC);
        cyc("rt_rwb",    1'b0, RT,  E_RWB);
        cyc("beq_fetch", 1'b1, BEQ, E_FGO);
        cyc("beq_decode",1'b1, BEQ, E_DEC);
        cyc("beq_branch",1'b1, BEQ, E_BRANCH);
        cyc("j_fetch",   1'b1, J,   E_FGO);
        cyc("j_decode",  1'b1, J,   E_DEC);
        cyc("j_jump",    1'b1, J,   E_JUMP);

        // FETCH stall for three cycles, then an illegal opcode in DECODE
        cyc("fstall0",   1'b0, BAD, E_FWAIT);
        cyc("fstall1",   1'b0, BAD, E_FWAIT);
        cyc("fstall2",   1'b0, BAD, E_FWAIT);
        cyc("fgo",       1'b1, BAD, E_FGO);
        cyc("illegal",   1'b1, BAD, E_DECBAD);

        // LW with one wait cycle in MEMRD
        cyc("lw2_fetch", 1'b1, LW, E_FGO);
        cyc("lw2_decode",1'b1, LW, E_DEC);
        cyc("lw2_memadr",1'b1, LW, E_MEMADR);
        cyc("lw2_memrd0",1'b0, LW, E_MEMRD);
        cyc("lw2_memrd1",1'b1, LW, E_MEMRD);
        cyc("lw2_memwb", 1'b1, LW, E_MEMWB);

        // ADDI aborted by a reset pulse in the middle of ADDIEX
        cyc("addi_fetch", 1'b1, ADDI, E_FGO);
        cyc("addi_decode",1'b1, ADDI, E_DEC);
        MemReady = 1'b1;
        #1;
        check("addi_ex", outs(), E_ADDIEX);
        #1;
        Reset = 1'b0;
        #1;
        check("midreset_async", outs(), E_ZERO);
        @(negedge Clk);
        #1;
        check("midreset_held", outs(), E_ZERO);
        Reset = 1'b1;
        #1;
        check("resume_fetch", outs(), E_FGO);
        @(negedge Clk);
        cyc("addi2_decode",1'b1, ADDI, E_DEC);
        cyc("addi2_ex",    1'b1, ADDI, E_ADDIEX);
        cyc("addi2_wb",    1'b1, ADDI, E_ADDIWB);
        cyc("addi2_done",  1'b0, ADDI, E_FWAIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
